// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the priority encoder / span decoder pair.
// The result struct is sized for the default 16-bit configuration used by the checker benches.
package priority_encoder_pkg;

  function automatic int ptr_size(input int width);
    return $clog2(width);
  endfunction

  localparam int ENC_WIDTH = 16;
  localparam int ENC_PTR   = ptr_size(ENC_WIDTH);

  typedef struct packed {
    logic [ENC_PTR-1:0]   left_idx;
    logic [ENC_PTR-1:0]   right_idx;
    logic [ENC_WIDTH-1:0] span;
    logic [ENC_PTR:0]     span_len;
    logic                 error;
  } span_result_t;

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot to binary index conversion with integrity flags.
// Each index bit is the OR of all mask bits whose position has that bit set.
module onehot_to_idx #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         mask,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     is_onehot,
  output logic                     is_zero
);
  import priority_encoder_pkg::*;

  localparam int PTR_SIZE = ptr_size(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    idx = '0;
    for (int b = 0; b < PTR_SIZE; b++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i[b]) idx[b] = idx[b] | mask[i];
      end
    end
  end

  assign is_zero   = (mask == '0);
  assign is_onehot = !is_zero && ((mask & (mask - ONE)) == '0);

endmodule

// File: rtl/priority_span_decoder.sv
// Decodes the encoder's {left, right} one-hot masks into indices, a span mask and span length.
// Two-stage valid/ready pipeline; malformed beats are flagged and their data zeroed.
module priority_span_decoder #(
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [WIDTH-1:0]         data_left_i,
  input  logic [WIDTH-1:0]         data_right_i,
  input  logic                     data_val_i,
  output logic                     data_ready_o,
  output logic [$clog2(WIDTH)-1:0] left_idx_o,
  output logic [$clog2(WIDTH)-1:0] right_idx_o,
  output logic [WIDTH-1:0]         span_o,
  output logic [$clog2(WIDTH):0]   span_len_o,
  output logic                     error_o,
  output logic                     data_val_o,
  input  logic                     data_ready_i
);
  import priority_encoder_pkg::*;

  localparam int PTR_SIZE = ptr_size(WIDTH);
  localparam logic [WIDTH:0]    ONE_W = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_SIZE:0] ONE_P = {{PTR_SIZE{1'b0}}, 1'b1};

  // Upper bound is built one bit wider so l = WIDTH-1 yields all ones, not zero.
  function automatic logic [WIDTH-1:0] span_mask(input logic [PTR_SIZE-1:0] l,
                                                 input logic [PTR_SIZE-1:0] r);
    logic [WIDTH:0] hi;
    logic [WIDTH:0] lo;
    hi = (ONE_W << ({1'b0, l} + ONE_P)) - ONE_W;
    lo = (ONE_W << r) - ONE_W;
    return hi[WIDTH-1:0] & ~lo[WIDTH-1:0];
  endfunction

  function automatic logic [PTR_SIZE:0] span_len(input logic [PTR_SIZE-1:0] l,
                                                 input logic [PTR_SIZE-1:0] r);
    return {1'b0, l} - {1'b0, r} + ONE_P;
  endfunction

  logic [PTR_SIZE-1:0] l_idx_c, r_idx_c;
  logic                l_one_c, l_zero_c, r_one_c, r_zero_c;
  logic                empty_c, err_c;

  logic                vld_p1, vld_p2;
  logic                adv_p1, adv_p2;
  logic [PTR_SIZE-1:0] l_idx_p1, r_idx_p1;
  logic                empty_p1, err_p1;

  logic [PTR_SIZE-1:0] l_idx_p2, r_idx_p2;
  logic [WIDTH-1:0]    span_p2;
  logic [PTR_SIZE:0]   len_p2;
  logic                err_p2;

  onehot_to_idx #(.WIDTH(WIDTH)) u_left (
    .mask      (data_left_i),
    .idx       (l_idx_c),
    .is_onehot (l_one_c),
    .is_zero   (l_zero_c)
  );

  onehot_to_idx #(.WIDTH(WIDTH)) u_right (
    .mask      (data_right_i),
    .idx       (r_idx_c),
    .is_onehot (r_one_c),
    .is_zero   (r_zero_c)
  );

  assign empty_c = l_zero_c & r_zero_c;
  assign err_c   = (!l_one_c && !l_zero_c) || (!r_one_c && !r_zero_c) ||
                   (l_zero_c ^ r_zero_c) || (l_one_c && r_one_c && (l_idx_c < r_idx_c));

  assign adv_p2       = !vld_p2 || data_ready_i;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign data_ready_o = adv_p1;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= data_val_i;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: indices and integrity flags of the accepted beat
  always_ff @(posedge clk_i) begin
    if (adv_p1 && data_val_i) begin
      l_idx_p1 <= l_idx_c;
      r_idx_p1 <= r_idx_c;
      empty_p1 <= empty_c;
      err_p1   <= err_c;
    end
  end

  // Stage 2: span build; held while the output beat is stalled
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      l_idx_p2 <= '0;
      r_idx_p2 <= '0;
      span_p2  <= '0;
      len_p2   <= '0;
      err_p2   <= 1'b0;
    end else if (adv_p2 && vld_p1) begin
      err_p2 <= err_p1;
      if (err_p1 || empty_p1) begin
        l_idx_p2 <= '0;
        r_idx_p2 <= '0;
        span_p2  <= '0;
        len_p2   <= '0;
      end else begin
        l_idx_p2 <= l_idx_p1;
        r_idx_p2 <= r_idx_p1;
        span_p2  <= span_mask(l_idx_p1, r_idx_p1);
        len_p2   <= span_len(l_idx_p1, r_idx_p1);
      end
    end
  end

  assign data_val_o  = vld_p2;
  assign error_o     = vld_p2 && err_p2;
  assign left_idx_o  = l_idx_p2;
  assign right_idx_o = r_idx_p2;
  assign span_o      = span_p2;
  assign span_len_o  = len_p2;

endmodule

// File: tb/tb_priority_span_decoder.sv
// Self-checking bench for priority_span_decoder: directed literal vectors plus a
// scoreboard of model results compared on every consumed output beat.
module tb_priority_span_decoder;
  import priority_encoder_pkg::*;

  localparam int W = 16;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         arstn;
  logic [W-1:0] data_left_i, data_right_i;
  logic         data_val_i, data_ready_o;
  logic [P-1:0] left_idx_o, right_idx_o;
  logic [W-1:0] span_o;
  logic [P:0]   span_len_o;
  logic         error_o, data_val_o, data_ready_i;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_disc = 0;
  int rdy_mode = 0;
  span_result_t exp_q[$];

  always #5 clk = ~clk;

  priority_span_decoder #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .left_idx_o   (left_idx_o),
    .right_idx_o  (right_idx_o),
    .span_o       (span_o),
    .span_len_o   (span_len_o),
    .error_o      (error_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: find bit positions and count ones, then apply the decoding rules directly.
  function automatic span_result_t model(input logic [W-1:0] l, input logic [W-1:0] r);
    span_result_t res;
    int li, ri;
    res = '0;
    li = -1;
    ri = -1;
    for (int i = 0; i < W; i++) begin
      if (l[i]) li = i;
      if (r[i]) ri = i;
    end
    if ($countones(l) == 0 && $countones(r) == 0) return res;
    if ($countones(l) != 1 || $countones(r) != 1 || li < ri) begin
      res.error = 1'b1;
      return res;
    end
    res.left_idx  = li[P-1:0];
    res.right_idx = ri[P-1:0];
    for (int i = ri; i <= li; i++) res.span[i] = 1'b1;
    res.span_len = 5'(li - ri + 1);
    return res;
  endfunction

  function automatic logic [W-1:0] msb_oh(input logic [W-1:0] d);
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    msb_oh = '0;
    for (int i = 0; i < W; i++) if (d[i]) msb_oh = one << i;
  endfunction

  function automatic span_result_t dut_out();
    span_result_t c;
    c.left_idx  = left_idx_o;
    c.right_idx = right_idx_o;
    c.span      = span_o;
    c.span_len  = span_len_o;
    c.error     = error_o;
    return c;
  endfunction

  // Compare process: all sampling on the falling edge, between input updates and the next rising edge.
  span_result_t prev_out;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    span_result_t cur, e;
    cur = dut_out();
    if (!arstn) begin
      n_disc += exp_q.size();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", 32'(cur), 32'(prev_out));
        check("stall_val", 32'(data_val_o), 32'(1));
      end
      check("ready_o", 32'(data_ready_o), 32'(!(exp_q.size() == 2 && !data_ready_i)));
      if (data_val_o && data_ready_i) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(data_val_o), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("beat", 32'(cur), 32'(e));
          n_out++;
        end
      end
      if (data_val_i && data_ready_o) begin
        exp_q.push_back(model(data_left_i, data_right_i));
        n_acc++;
      end
      prev_stall = data_val_o && !data_ready_i;
      prev_out = cur;
    end
  end

  initial begin
    data_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: data_ready_i = 1'b1;
        1: data_ready_i = 1'($urandom_range(0, 1));
        default: data_ready_i = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    int n;
    @(posedge clk);
    #1;
    data_left_i = l;
    data_right_i = r;
    data_val_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!data_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready_o) check("accept_timeout", 32'(data_ready_o), 32'(1));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic directed(input string name, input logic [W-1:0] l, input logic [W-1:0] r,
                          input logic [P-1:0] el, input logic [P-1:0] er,
                          input logic [W-1:0] es, input logic [P:0] elen, input logic eerr);
    span_result_t exp_r;
    exp_r.left_idx  = el;
    exp_r.right_idx = er;
    exp_r.span      = es;
    exp_r.span_len  = elen;
    exp_r.error     = eerr;
    drain();
    send(l, r);
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
    check({name, "_lat1"}, 32'(data_val_o), 32'(0));
    @(posedge clk);
    #2;
    check({name, "_val"}, 32'(data_val_o), 32'(1));
    check({name, "_data"}, 32'(dut_out()), 32'(exp_r));
  endtask

  initial begin
    span_result_t m;
    logic [W-1:0] d, l, r;
    arstn = 1'b0;
    data_val_i = 1'b0;
    data_left_i = '0;
    data_right_i = '0;

    m = model(16'h0080, 16'h0004);
    check("model_pin_span", 32'(m.span), 32'h00FC);
    check("model_pin_len", 32'(m.span_len), 32'd6);
    m = model(16'h8000, 16'h0001);
    check("model_pin_full", 32'(m.span), 32'hFFFF);
    m = model(16'h0002, 16'h0010);
    check("model_pin_err", 32'(m.error), 32'd1);

    #2;
    check("rst_val_o", 32'(data_val_o), 32'(0));
    check("rst_err_o", 32'(error_o), 32'(0));
    check("rst_data", 32'(dut_out()), 32'(0));
    #11 arstn = 1'b1;
    #1 check("rst_ready_o", 32'(data_ready_o), 32'(1));

    directed("basic",   16'h0080, 16'h0004, 4'd7,  4'd2,  16'h00FC, 5'd6,  1'b0);
    directed("top_one", 16'h8000, 16'h8000, 4'd15, 4'd15, 16'h8000, 5'd1,  1'b0);
    directed("full",    16'h8000, 16'h0001, 4'd15, 4'd0,  16'hFFFF, 5'd16, 1'b0);
    directed("lsb_one", 16'h0001, 16'h0001, 4'd0,  4'd0,  16'h0001, 5'd1,  1'b0);
    directed("empty",   16'h0000, 16'h0000, 4'd0,  4'd0,  16'h0000, 5'd0,  1'b0);
    directed("multi",   16'h0300, 16'h0001, 4'd0,  4'd0,  16'h0000, 5'd0,  1'b1);
    directed("order",   16'h0002, 16'h0010, 4'd0,  4'd0,  16'h0000, 5'd0,  1'b1);
    directed("onezero", 16'h0010, 16'h0000, 4'd0,  4'd0,  16'h0000, 5'd0,  1'b1);
    directed("after_err", 16'h0400, 16'h0040, 4'd10, 4'd6, 16'h07C0, 5'd5, 1'b0);

    drain();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(16'h0001 << (i + 8), 16'h0001 << i);
    idle();
    drain();
    check("b2b_count", 32'(n_out), 32'(n_acc - n_disc));

    rdy_mode = 2;
    send(16'h0100, 16'h0010);
    send(16'h0020, 16'h0020);
    idle();
    check("inflight_val", 32'(data_val_o), 32'(1));
    check("inflight_ready", 32'(data_ready_o), 32'(0));
    #2 arstn = 1'b0;
    #1;
    check("async_val_o", 32'(data_val_o), 32'(0));
    check("async_data", 32'(dut_out()), 32'(0));
    repeat (2) @(posedge clk);
    #3 arstn = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2 check("post_rst_idle", 32'(data_val_o), 32'(0));
    end

    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        l = 16'($urandom);
        r = 16'($urandom);
      end else if ($urandom_range(0, 31) == 0) begin
        l = '0;
        r = '0;
      end else begin
        l = msb_oh(d);
        r = d & (~d + 16'd1);
      end
      send(l, r);
    end
    idle();
    drain();
    check("final_count", 32'(n_out), 32'(n_acc - n_disc));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
